// File: rtl/hs32_wbm_bridge_pkg.sv
// Shared definitions for the hs32 Wishbone master bridge and future Wishbone blocks.
// Contents: bridge FSM state encoding, default watchdog limit, byte-select width helper.
package hs32_wbm_bridge_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StBus  = 1'b1
  } state_e;

  localparam int unsigned DefTimeout = 255;

  // One byte-select line per data byte.
  function automatic int unsigned sel_width(int unsigned dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/hs32_wbm_bridge_if.sv
// Bundle of the CPU request/response handshake and the Wishbone master bus.
// modport master: bridge view (drives req_ready, rsp_*, wbm_*_o).
// modport slave:  environment view (CPU + Wishbone slave side).
interface hs32_wbm_bridge_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  import hs32_wbm_bridge_pkg::*;

  localparam int unsigned SW = sel_width(DW);

  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [SW-1:0] req_sel;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_dtw;
  logic          rsp_valid;
  logic          rsp_err;
  logic [DW-1:0] rsp_dtr;
  logic          wbm_cyc_o;
  logic          wbm_stb_o;
  logic          wbm_we_o;
  logic [SW-1:0] wbm_sel_o;
  logic [AW-1:0] wbm_adr_o;
  logic [DW-1:0] wbm_dat_o;
  logic [DW-1:0] wbm_dat_i;
  logic          wbm_ack_i;
  logic          wbm_err_i;

  modport master (
    input  req_valid, req_we, req_sel, req_addr, req_dtw, wbm_dat_i, wbm_ack_i, wbm_err_i,
    output req_ready, rsp_valid, rsp_err, rsp_dtr,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );

  modport slave (
    output req_valid, req_we, req_sel, req_addr, req_dtw, wbm_dat_i, wbm_ack_i, wbm_err_i,
    input  req_ready, rsp_valid, rsp_err, rsp_dtr,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );

endinterface

// File: rtl/hs32_wbm_bridge_timeout.sv
// Bus watchdog counter.
// Ports: clk, rst (sync, active-high), clr (return to 0), en (count this cycle),
//        expired (counter has reached TIMEOUT-1 while enabled).
// TIMEOUT=0 disables the watchdog: expired is tied low and no counter is built.
module hs32_wbm_bridge_timeout #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  if (TIMEOUT > 0) begin : g_cnt
    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
        cnt_d = '0;
      end else if (en) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign expired = en && (cnt_q == CntW'(TIMEOUT - 1));
  end else begin : g_off
    logic unused_in;
    assign unused_in = ^{clk, rst, clr, en};
    assign expired   = 1'b0;
  end

endmodule

// File: rtl/hs32_wbm_bridge.sv
// Wishbone B4 classic master for the hs32 core: one CPU request -> one Wishbone cycle,
// answered by a one-cycle rsp_valid strobe (rsp_err on bus error, timeout or sel==0).
// Ports: wb_clk_i, wb_rst_i (sync, active-high), bus (hs32_wbm_bridge_if.master:
//        req_*/rsp_* CPU handshake and wbm_* Wishbone master signals).
// All outputs are registered except req_ready.
module hs32_wbm_bridge
  import hs32_wbm_bridge_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = DefTimeout
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  hs32_wbm_bridge_if.master         bus
);

  localparam int unsigned SW = sel_width(DW);

  state_e        state_q, state_d;
  logic          cyc_q, cyc_d;
  logic          we_q, we_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] dat_q, dat_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_err_q, rsp_err_d;
  logic [DW-1:0] rsp_dtr_q, rsp_dtr_d;

  logic in_bus;
  logic expired;
  logic end_cycle;

  assign in_bus    = (state_q == StBus);
  assign end_cycle = in_bus && (bus.wbm_ack_i || bus.wbm_err_i || expired);

  hs32_wbm_bridge_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .clr     (end_cycle),
    .en      (in_bus),
    .expired (expired)
  );

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_dtr_d   = rsp_dtr_q;

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          if (bus.req_sel != '0) begin
            state_d = StBus;
            cyc_d   = 1'b1;
            we_d    = bus.req_we;
            sel_d   = bus.req_sel;
            adr_d   = bus.req_addr;
            dat_d   = bus.req_dtw;
          end else begin
            // Nothing to transfer: answer with an error, no bus cycle.
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end
        end
      end
      StBus: begin
        if (end_cycle) begin
          state_d     = StIdle;
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          // err and timeout both report an error; err wins over a simultaneous ack.
          if (bus.wbm_err_i || !bus.wbm_ack_i) begin
            rsp_err_d = 1'b1;
          end else if (!we_q) begin
            rsp_dtr_d = bus.wbm_dat_i;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= StIdle;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_dtr_q   <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_dtr_q   <= rsp_dtr_d;
    end
  end

  assign bus.req_ready = (state_q == StIdle) && !wb_rst_i;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_dtr   = rsp_dtr_q;
  assign bus.wbm_cyc_o = cyc_q;
  assign bus.wbm_stb_o = cyc_q;
  assign bus.wbm_we_o  = we_q;
  assign bus.wbm_sel_o = sel_q;
  assign bus.wbm_adr_o = adr_q;
  assign bus.wbm_dat_o = dat_q;

endmodule
